// File: rtl/write_phase_if.sv
// write_phase_if: writeback-stage bundle between execute and register file.
// Carries the write requests, load return data, read ports and status outputs.
interface write_phase_if;
  logic        in_valid;
  logic        in_is_load;
  logic        in_we;
  logic [4:0]  in_dst;
  logic [1:0]  in_bmd;
  logic [63:0] in_d;
  logic [2:0]  in_ld_offset;
  logic        in_efl_we;
  logic [63:0] in_efl;
  logic [63:0] ld_data;
  logic [4:0]  rd_idx_a;
  logic [4:0]  rd_idx_b;
  logic [63:0] rd_data_a;
  logic [63:0] rd_data_b;
  logic [63:0] efl;
  logic [16:0] busy;
  logic [63:0] retired;

  modport master (
    output in_valid, in_is_load, in_we, in_dst, in_bmd, in_d,
    output in_ld_offset, in_efl_we, in_efl, ld_data,
    output rd_idx_a, rd_idx_b,
    input  rd_data_a, rd_data_b, efl, busy, retired
  );

  modport slave (
    input  in_valid, in_is_load, in_we, in_dst, in_bmd, in_d,
    input  in_ld_offset, in_efl_we, in_efl, ld_data,
    input  rd_idx_a, rd_idx_b,
    output rd_data_a, rd_data_b, efl, busy, retired
  );
endinterface

// File: rtl/write_phase.sv
// write_phase: writeback stage arbitrating EFL, ALU and load writes.
// Optional WB_BYPASS_EN: reads and efl forward the value written at the coming edge.
module write_phase #(
  parameter int LOAD_LATENCY = 1,
  parameter int REG_N        = 17
) (
  input logic        clk,
  input logic        rstn,
  write_phase_if.slave bus
);
  localparam int EFL_IDX = 16;

  typedef struct packed {
    logic       vld;
    logic [4:0] dst;
    logic [1:0] bmd;
    logic [2:0] off;
  } ld_t;

  logic [63:0] regs_q [REG_N];
  logic [63:0] regs_d [REG_N];
  ld_t         pipe_q [LOAD_LATENCY];
  logic [63:0] ret_q;
  logic [REG_N-1:0] busy_w;

  ld_t         ld_end;
  logic        alu_wr;
  logic        ld_wr;
  logic        efl_wr;
  logic        ld_issue;
  logic [63:0] ld_sh;
  logic        rd_ok_a;
  logic        rd_ok_b;

  function automatic logic [63:0] wmerge(
    input logic [63:0] old,
    input logic [63:0] v,
    input logic [1:0]  bmd
  );
    unique case (bmd)
      2'b00:   wmerge = {old[63:8], v[7:0]};
      2'b01:   wmerge = {32'd0, v[31:0]};
      default: wmerge = v;
    endcase
  endfunction

  assign ld_end   = pipe_q[LOAD_LATENCY-1];
  assign ld_issue = bus.in_valid & bus.in_is_load;
  assign efl_wr   = bus.in_valid & bus.in_efl_we;
  assign alu_wr   = bus.in_valid & bus.in_we & ~bus.in_is_load
                  & (int'(bus.in_dst) < REG_N);
  assign ld_wr    = ld_end.vld & (int'(ld_end.dst) < REG_N);
  assign ld_sh    = bus.ld_data >> {ld_end.off, 3'b000};

  // Next register file: load first, ALU overrides, EFL write overrides all.
  always_comb begin
    regs_d = regs_q;
    if (ld_wr)
      regs_d[ld_end.dst] = wmerge(regs_q[ld_end.dst], ld_sh, ld_end.bmd);
    if (alu_wr)
      regs_d[bus.in_dst] = wmerge(regs_q[bus.in_dst], bus.in_d, bus.in_bmd);
    if (efl_wr)
      regs_d[EFL_IDX] = bus.in_efl;
  end

  // Register file, load tracking pipeline and retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_N; i++)
        regs_q[i] <= '0;
      for (int i = 0; i < LOAD_LATENCY; i++)
        pipe_q[i] <= '0;
      ret_q <= '0;
    end else begin
      regs_q <= regs_d;
      pipe_q[0] <= '{vld: ld_issue, dst: bus.in_dst,
                     bmd: bus.in_bmd, off: bus.in_ld_offset};
      for (int i = 1; i < LOAD_LATENCY; i++)
        pipe_q[i] <= pipe_q[i-1];
      ret_q <= ret_q + 64'(bus.in_valid);
    end
  end

  // A register is busy while any in-flight load still targets it.
  always_comb begin
    busy_w = '0;
    for (int i = 0; i < LOAD_LATENCY; i++)
      if (pipe_q[i].vld && (int'(pipe_q[i].dst) < REG_N))
        busy_w[pipe_q[i].dst] = 1'b1;
  end

  assign rd_ok_a = int'(bus.rd_idx_a) < REG_N;
  assign rd_ok_b = int'(bus.rd_idx_b) < REG_N;

`ifdef WB_BYPASS_EN
  assign bus.rd_data_a = rd_ok_a ? regs_d[bus.rd_idx_a] : '0;
  assign bus.rd_data_b = rd_ok_b ? regs_d[bus.rd_idx_b] : '0;
  assign bus.efl       = regs_d[EFL_IDX];
`else
  assign bus.rd_data_a = rd_ok_a ? regs_q[bus.rd_idx_a] : '0;
  assign bus.rd_data_b = rd_ok_b ? regs_q[bus.rd_idx_b] : '0;
  assign bus.efl       = regs_q[EFL_IDX];
`endif

  assign bus.busy    = busy_w;
  assign bus.retired = ret_q;
endmodule
